// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall logic: FSM encoding,
// register-zero constant and the control words driven to the front end.
package pipe_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Front-end control word: register enables plus the NOP-insertion controls.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic idex_bubble;
    logic ifid_flush;
  } ctrl_t;

  // Normal flow: everything advances, nothing is squashed.
  localparam ctrl_t CTRL_RUN      = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                      idex_bubble: 1'b0, ifid_flush: 1'b0};
  // NOP fill: front end frozen, ID/EX and IF/ID loaded with NOPs (held in reset).
  localparam ctrl_t CTRL_NOP_FILL = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
                                      idex_bubble: 1'b1, ifid_flush: 1'b1};
  // Load-use: hold PC and IF/ID one cycle, push a NOP bubble into EX.
  localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b1,
                                      idex_bubble: 1'b1, ifid_flush: 1'b0};
  // Taken branch: load the target, squash the two younger instructions.
  localparam ctrl_t CTRL_BRANCH   = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                      idex_bubble: 1'b1, ifid_flush: 1'b1};
  // Mul/div occupying EX: the whole front end freezes.
  localparam ctrl_t CTRL_MD_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
                                      idex_bubble: 1'b0, ifid_flush: 1'b0};

endpackage

// File: rtl/hazard_stall_unit_md_countdown.sv
// Mul/div occupancy countdown: loadable down-counter that flags its final cycle.
module md_countdown #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          done
);

  // Load on mul/div entry, count down while busy, never wrap below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit: load-use bubbles, mul/div front-end freeze, branch flush,
// and a saturating count of cycles in which the PC was held.
//
// Handshake note: there is no valid/ready pair here; every output is a
// per-cycle level that the pipeline registers consume on the next rising edge.
module hazard_stall_unit
  import pipe_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_rs,
  input  logic [4:0]       IFID_rt,
  input  logic             IFID_use_rt,
  input  logic [4:0]       IDEX_rt,
  input  logic             IDEX_memread,
  input  logic             IDEX_md,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             fsm_state
);

  localparam int MDW = 4;

  hz_state_t        state, next_state;
  ctrl_t            ctrl;
  logic             load_use;
  logic             md_load, md_dec, md_last;
  logic [MDW-1:0]   md_cnt;

  assign load_use = IDEX_memread && (IDEX_rt != REG_ZERO) &&
                    ((IDEX_rt == IFID_rs) || (IFID_use_rt && (IDEX_rt == IFID_rt)));

  md_countdown #(.CW(MDW)) u_md_countdown (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (md_load),
    .load_val (MDW'(MD_LAT - 1)),
    .dec      (md_dec),
    .cnt      (md_cnt),
    .done     (md_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  // Next state and front-end controls; priority: reset, mul/div, branch, load-use.
  always_comb begin
    ctrl       = CTRL_RUN;
    next_state = state;
    md_load    = 1'b0;
    md_dec     = 1'b0;
    md_done    = 1'b0;
    if (!rst_n) begin
      ctrl       = CTRL_NOP_FILL;
      next_state = RUN;
    end else begin
      case (state)
        RUN: begin
          if (IDEX_md) begin
            ctrl       = CTRL_MD_STALL;
            md_load    = 1'b1;
            next_state = MD_BUSY;
          end else if (branch_taken) begin
            ctrl = CTRL_BRANCH;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end
        end
        MD_BUSY: begin
          ctrl   = CTRL_MD_STALL;
          md_dec = 1'b1;
          if (md_last) begin
            md_done    = 1'b1;
            next_state = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_write  = ctrl.idex_write;
  assign idex_bubble = ctrl.idex_bubble;
  assign ifid_flush  = ctrl.ifid_flush;
  assign fsm_state   = state;

  // Count held-PC cycles, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a queue-based scoreboard.
module tb_hazard_stall_unit;

  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  // Expected output words {pc, ifid, idex, bubble, flush, md_done}.
  localparam logic [5:0] O_RUN = 6'b111000;
  localparam logic [5:0] O_RST = 6'b000110;
  localparam logic [5:0] O_LU  = 6'b001100;
  localparam logic [5:0] O_BR  = 6'b111110;
  localparam logic [5:0] O_MD  = 6'b000000;
  localparam logic [5:0] O_MDD = 6'b000001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       IFID_rs = '0, IFID_rt = '0, IDEX_rt = '0;
  logic             IFID_use_rt = 1'b0, IDEX_memread = 1'b0, IDEX_md = 1'b0, branch_taken = 1'b0;
  logic             pc_write, ifid_write, idex_write, idex_bubble, ifid_flush, md_done;
  logic [CNT_W-1:0] stall_cycles;
  logic             fsm_state;

  // Scoreboard entry: {outputs[5:0], state, stall_cycles[3:0]}
  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          step_no = 0;
  bit          stim_done = 1'b0;

  hazard_stall_unit #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IFID_rs      (IFID_rs),
    .IFID_rt      (IFID_rt),
    .IFID_use_rt  (IFID_use_rt),
    .IDEX_rt      (IDEX_rt),
    .IDEX_memread (IDEX_memread),
    .IDEX_md      (IDEX_md),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .md_done      (md_done),
    .stall_cycles (stall_cycles),
    .fsm_state    (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs just after the rising edge, queue the expectation.
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic use_rt, input logic [4:0] ex_rt, input logic memread,
                      input logic md, input logic br, input logic [5:0] exp_o,
                      input logic exp_st, input logic [3:0] exp_cnt);
    @(posedge clk);
    #1;
    rst_n        = rst;
    IFID_rs      = rs;
    IFID_rt      = rt;
    IFID_use_rt  = use_rt;
    IDEX_rt      = ex_rt;
    IDEX_memread = memread;
    IDEX_md      = md;
    branch_taken = br;
    exp_q.push_back({exp_o, exp_st, exp_cnt});
  endtask

  task automatic idle(input logic [5:0] exp_o, input logic exp_st, input logic [3:0] exp_cnt);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp_o, exp_st, exp_cnt);
  endtask

  // Monitor: on the falling edge compare live outputs against the oldest expectation.
  initial begin
    logic [10:0] exp_w, act_w;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        act_w = {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush, md_done,
                 fsm_state, stall_cycles};
        n_checks++;
        step_no++;
        if (act_w !== exp_w) begin
          n_fail++;
          $display("FAIL step%0d: got pc/ifid/idex/bub/flush/done=%b state=%b stall=%0d, want %b state=%b stall=%0d",
                   step_no, act_w[10:5], act_w[4], act_w[3:0], exp_w[10:5], exp_w[4], exp_w[3:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    // Reset held three cycles with random inputs.
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), O_RST, 1'b0, 4'd0);
    idle(O_RUN, 1'b0, 4'd0);

    // Load-use on rs, resolves next cycle.
    step(1'b1, 5'd8, 5'd2, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, O_LU, 1'b0, 4'd0);
    step(1'b1, 5'd8, 5'd2, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, O_RUN, 1'b0, 4'd1);

    // Register zero never stalls; rt match ignored unless rt is read.
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN, 1'b0, 4'd1);
    step(1'b1, 5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, O_RUN, 1'b0, 4'd1);
    step(1'b1, 5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, O_LU, 1'b0, 4'd1);
    idle(O_RUN, 1'b0, 4'd2);

    // Mul/div: four stall cycles, done on the last; hazards ignored while busy.
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MD, 1'b0, 4'd2);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MD, 1'b1, 4'd3);
    step(1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, O_MD, 1'b1, 4'd4);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_MDD, 1'b1, 4'd5);
    idle(O_RUN, 1'b0, 4'd6);

    // Branch beats load-use, stall not counted.
    step(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, O_BR, 1'b0, 4'd6);
    idle(O_RUN, 1'b0, 4'd6);

    // Reset during the second mul/div cycle aborts it.
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MD, 1'b0, 4'd6);
    idle(O_MD, 1'b1, 4'd7);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, 1'b0, 4'd0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, 1'b0, 4'd0);
    idle(O_RUN, 1'b0, 4'd0);
    idle(O_RUN, 1'b0, 4'd0);

    // Back-to-back mul/divs drive the 4-bit counter into saturation.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MD, 1'b0, 4'(4 * k));
      idle(O_MD,  1'b1, 4'(4 * k + 1));
      idle(O_MD,  1'b1, 4'(4 * k + 2));
      idle(O_MDD, 1'b1, 4'(4 * k + 3));
    end
    idle(O_RUN, 1'b0, 4'd15);
    step(1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, O_LU, 1'b0, 4'd15);
    idle(O_RUN, 1'b0, 4'd15);
    stim_done = 1'b1;
  end

  // Final report, with a bounded drain of the scoreboard.
  initial begin
    int guard;
    guard = 0;
    while (!stim_done && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    if (!stim_done || exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: stim_done=%0b pending=%0d, want stim_done=1 pending=0",
               stim_done, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
